// File: rtl/data_sram_responder.sv
// data_sram_responder: responder end of the data SRAM bus used by EX/MEM.
// Single-port, word-organised, byte-writable 32-bit memory with a parameterised
// access latency (1..8). For LATENCY > 1 a small IDLE/BUSY/HOLD FSM latches the
// request, holds stallreq for LATENCY-1 cycles and performs the access once.
// Optional feature macro: DSRAM_ERR_EN adds an out-of-range check on the upper
// address bits, suppresses such writes, zeroes such reads and raises a sticky
// data_sram_err output. Without it the upper address bits simply alias.
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq
`ifdef DSRAM_ERR_EN
  ,
  output logic        data_sram_err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  // The single access port into the memory: asserted for exactly one edge per
  // accepted request, carrying either the live bus or the latched request.
  logic              acc_fire;
  logic [3:0]        acc_wen;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_oor;

  assign acc_idx = acc_addr[ADDR_W+1:2];

`ifdef DSRAM_ERR_EN
  assign acc_oor = |acc_addr[31:ADDR_W+2];
`else
  assign acc_oor = 1'b0;
`endif

  // Byte offset bits are never used and upper bits alias in the default build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:ADDR_W+2], acc_addr[1:0]};

  generate
    if (LATENCY == 1) begin : g_lat1
      // Single-cycle responder: every request is performed at the edge ending
      // its own cycle, so no stall is ever needed.
      assign acc_fire  = data_sram_en & ~rst;
      assign acc_wen   = data_sram_wen;
      assign acc_addr  = data_sram_addr;
      assign acc_wdata = data_sram_wdata;
      assign stallreq  = 1'b0;
    end else begin : g_latn
      state_t      state_q, state_d;
      logic [3:0]  cnt_q, cnt_d;
      logic [3:0]  req_wen_q;
      logic [31:0] req_addr_q;
      logic [31:0] req_wdata_q;
      logic        latch_req;
      logic        use_bus;
      logic        fire_raw;
      logic        stall_raw;

      // State and countdown register, cleared by reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // Request capture: the bus is only looked at in IDLE, later cycles use this copy.
      always_ff @(posedge clk) begin
        if (latch_req) begin
          req_wen_q   <= data_sram_wen;
          req_addr_q  <= data_sram_addr;
          req_wdata_q <= data_sram_wdata;
        end
      end

      // Next-state, stall and access-strobe decode; reset overrides everything.
      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_req = 1'b0;
        use_bus   = 1'b0;
        fire_raw  = 1'b0;
        stall_raw = 1'b0;
        case (state_q)
          IDLE: begin
            stall_raw = data_sram_en;
            if (data_sram_en) begin
              latch_req = 1'b1;
              if (LATENCY == 2) begin
                // The request registers are not loaded yet, so use the bus.
                fire_raw = 1'b1;
                use_bus  = 1'b1;
                state_d  = HOLD;
              end else begin
                cnt_d   = 4'(LATENCY - 2);
                state_d = BUSY;
              end
            end
          end
          BUSY: begin
            stall_raw = 1'b1;
            if (cnt_q == 4'd1) begin
              fire_raw = 1'b1;
              state_d  = HOLD;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
          HOLD: begin
            // The pipeline still shows the finished request; never re-accept it.
            state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
        if (rst) begin
          latch_req = 1'b0;
          fire_raw  = 1'b0;
          stall_raw = 1'b0;
        end
      end

      assign stallreq  = stall_raw;
      assign acc_fire  = fire_raw;
      assign acc_wen   = use_bus ? data_sram_wen   : req_wen_q;
      assign acc_addr  = use_bus ? data_sram_addr  : req_addr_q;
      assign acc_wdata = use_bus ? data_sram_wdata : req_wdata_q;
    end
  endgenerate

  // One byte-wide RAM per lane so each lane maps onto a plain block RAM with
  // its own write enable and registered read output.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_q;

      // Lane write port: only enabled bytes of in-range writes land.
      always_ff @(posedge clk) begin
        if (acc_fire && acc_wen[gi] && !acc_oor) begin
          lane_mem[acc_idx] <= acc_wdata[8*gi +: 8];
        end
      end

      // Lane read register: loads only on reads, otherwise holds its value.
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_rd_q <= 8'h00;
        end else if (acc_fire && (acc_wen == 4'b0000)) begin
          lane_rd_q <= acc_oor ? 8'h00 : lane_mem[acc_idx];
        end
      end

      assign data_sram_rdata[8*gi +: 8] = lane_rd_q;
    end
  endgenerate

`ifdef DSRAM_ERR_EN
  logic err_q;

  // Sticky out-of-range flag, set at the edge where the bad access is performed.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (acc_fire && acc_oor) begin
      err_q <= 1'b1;
    end
  end

  assign data_sram_err = err_q;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: four instances with LATENCY 1..4 are driven
// one at a time by a pipeline-like driver that holds the bus until the stall
// drops. A word-array reference model predicts memory, rdata and err.
module tb_data_sram_responder;

  localparam int N  = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst;
  logic [N-1:0] en;
  logic [3:0]   wen   [N];
  logic [31:0]  addr  [N];
  logic [31:0]  wdata [N];
  logic [31:0]  rdata [N];
  logic [N-1:0] stall;
`ifdef DSRAM_ERR_EN
  logic [N-1:0] err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] mmem [N][1 << AW];
  logic [31:0] mrd  [N];
  logic        merr [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      data_sram_responder #(
        .ADDR_W (AW),
        .LATENCY(gi + 1)
      ) u_dut (
        .clk            (clk),
        .rst            (rst[gi]),
        .data_sram_en   (en[gi]),
        .data_sram_wen  (wen[gi]),
        .data_sram_addr (addr[gi]),
        .data_sram_wdata(wdata[gi]),
        .data_sram_rdata(rdata[gi]),
        .stallreq       (stall[gi])
`ifdef DSRAM_ERR_EN
        ,
        .data_sram_err  (err[gi])
`endif
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Apply one performed access to the model.
  task automatic model_access(input int d, input logic [3:0] w, input logic [31:0] a,
                              input logic [31:0] wd);
    int  idx;
    logic oor;
    idx = int'(a[AW+1:2]);
`ifdef DSRAM_ERR_EN
    oor = (a[31:AW+2] != '0);
`else
    oor = 1'b0;
`endif
    if (oor) merr[d] = 1'b1;
    if (w == 4'b0000) begin
      mrd[d] = oor ? 32'h0 : mmem[d][idx];
    end else if (!oor) begin
      for (int b = 0; b < 4; b++)
        if (w[b]) mmem[d][idx][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  // Check one cycle of instance d at the falling edge, then advance.
  task automatic sample(input int d, input logic exp_stall);
    @(negedge clk);
    check($sformatf("L%0d_stall", d + 1), 32'(stall[d]), 32'(exp_stall));
    check($sformatf("L%0d_rdata", d + 1), rdata[d], mrd[d]);
`ifdef DSRAM_ERR_EN
    check($sformatf("L%0d_err", d + 1), 32'(err[d]), 32'(merr[d]));
`endif
    @(posedge clk);
    #1;
  endtask

  // One pipeline access: hold the bus while stalled and through the HOLD cycle.
  // rst_at >= 0 pulses reset in that cycle of the access and abandons it.
  task automatic access(input int d, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input int rst_at);
    int lat;
    int acc_c;
    lat   = d + 1;
    acc_c = (lat == 1) ? 0 : lat - 2;
    en[d]    = 1'b1;
    wen[d]   = w;
    addr[d]  = a;
    wdata[d] = wd;
    for (int c = 0; c < lat; c++) begin
      if (c == rst_at) begin
        rst[d] = 1'b1;
        sample(d, 1'b0);
        mrd[d]  = 32'h0;
        merr[d] = 1'b0;
        rst[d]  = 1'b0;
        en[d]   = 1'b0;
        $display("L%0d %s addr=%08h wen=%h wdata=%08h reset in cycle %0d", lat,
                 (w == 0) ? "RD" : "WR", a, w, wd, c);
        return;
      end
      sample(d, c < lat - 1);
      if (c == acc_c) model_access(d, w, a, wd);
    end
    $display("L%0d %s addr=%08h wen=%h wdata=%08h rdata=%08h", lat,
             (w == 0) ? "RD" : "WR", a, w, wd, mrd[d]);
  endtask

  // Idle cycles with garbage on the bus and en low.
  task automatic idle(input int d, input int n);
    en[d]    = 1'b0;
    wen[d]   = 4'($urandom);
    addr[d]  = $urandom;
    wdata[d] = $urandom;
    repeat (n) sample(d, 1'b0);
  endtask

  initial begin
    logic [31:0] prior;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] wd;
    int          rc;

    rst = '1;
    en  = '1;
    for (int d = 0; d < N; d++) begin
      wen[d]   = 4'b0000;
      addr[d]  = $urandom & 32'h7C;
      wdata[d] = $urandom;
      mrd[d]   = 32'h0;
      merr[d]  = 1'b0;
    end
    @(posedge clk);
    #1;
    // Reset state, with requests present on the bus.
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        check($sformatf("L%0d_rst_stall", d + 1), 32'(stall[d]), 32'h0);
        check($sformatf("L%0d_rst_rdata", d + 1), rdata[d], 32'h0);
      end
      @(posedge clk);
      #1;
    end
    rst = '0;
    en  = '0;

    for (int d = 0; d < N; d++) begin
      // Fill the test region so every later read has a known value.
      for (int i = 0; i < 32; i++) access(d, 4'hF, 32'(i * 4), $urandom, -1);
      idle(d, 1);

      // Write then read back to back.
      access(d, 4'hF, 32'h10, 32'hDEADBEEF, -1);
      access(d, 4'h0, 32'h10, 32'h0, -1);
      check($sformatf("L%0d_rd10", d + 1), rdata[d], 32'hDEADBEEF);
      idle(d, 2);

      // Byte enables.
      access(d, 4'hF, 32'h20, 32'h11223344, -1);
      access(d, 4'b0101, 32'h20, 32'hAABBCCDD, -1);
      access(d, 4'h0, 32'h20, 32'h0, -1);
      check($sformatf("L%0d_bytes", d + 1), rdata[d], 32'h11BB33DD);
      idle(d, 1);

      // Isolated read: stall profile and single performed access.
      access(d, 4'h0, 32'h10, 32'h0, -1);
      idle(d, 2);

      // Back-to-back writes, then both read back; zero data is still a write.
      access(d, 4'hF, 32'h30, 32'hCAFE0030, -1);
      access(d, 4'hF, 32'h34, 32'h00000000, -1);
      access(d, 4'h0, 32'h30, 32'h0, -1);
      check($sformatf("L%0d_rd30", d + 1), rdata[d], 32'hCAFE0030);
      access(d, 4'h0, 32'h34, 32'h0, -1);
      check($sformatf("L%0d_rd34", d + 1), rdata[d], 32'h00000000);
      idle(d, 1);

      // Reset while the write is still pending: write is lost.
      if (d >= 2) begin
        prior = mmem[d][16];
        access(d, 4'hF, 32'h40, 32'h5, 1);
        check($sformatf("L%0d_rstmid_rdata", d + 1), rdata[d], 32'h0);
        check($sformatf("L%0d_rstmid_stall", d + 1), 32'(stall[d]), 32'h0);
        idle(d, 1);
        access(d, 4'h0, 32'h40, 32'h0, -1);
        check($sformatf("L%0d_rd40", d + 1), rdata[d], prior);
        idle(d, 1);
      end

      // Upper address bits: alias by default, out of range with the check on.
      access(d, 4'hF, 32'h00001000, 32'h12345678, -1);
      access(d, 4'h0, 32'h00001000, 32'h0, -1);
`ifdef DSRAM_ERR_EN
      check($sformatf("L%0d_oor_rdata", d + 1), rdata[d], 32'h0);
      check($sformatf("L%0d_oor_err", d + 1), 32'(err[d]), 32'h1);
`endif
      access(d, 4'h0, 32'h0, 32'h0, -1);
      idle(d, 2);

      // Randomised traffic.
      for (int t = 0; t < 40; t++) begin
        w  = ($urandom_range(1) == 1) ? 4'h0 : 4'($urandom);
        a  = {(($urandom_range(3) == 0) ? 20'($urandom) : 20'h0), 5'h00,
              5'($urandom_range(31)), 2'($urandom)};
        wd = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
        rc = (d > 0 && $urandom_range(15) == 0) ? int'($urandom_range(d, 1)) : -1;
        access(d, w, a, wd, rc);
        idle(d, int'($urandom_range(2)));
      end
      idle(d, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
